// File: rtl/pmem_responder_pkg.sv
// pmem_responder_pkg: shared line/word types and the responder state encoding.
package pmem_responder_pkg;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] cache_line;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_state_t;
endpackage

// File: rtl/pmem_responder_if.sv
// pmem_responder_if: cache-to-memory pmem_* line interface.
interface pmem_responder_if;
    import pmem_responder_pkg::*;
    lc3b_word  pmem_address;
    logic      pmem_read;
    logic      pmem_write;
    cache_line pmem_wdata;
    cache_line pmem_rdata;
    logic      pmem_resp;
    logic      pmem_error;
    modport master (output pmem_address, pmem_read, pmem_write, pmem_wdata,
                    input  pmem_rdata, pmem_resp, pmem_error);
    modport slave  (input  pmem_address, pmem_read, pmem_write, pmem_wdata,
                    output pmem_rdata, pmem_resp, pmem_error);
endinterface

// File: rtl/pmem_responder_array.sv
// pmem_responder_array: line storage with one registered read port and one write port, no reset.
module pmem_responder_array
    import pmem_responder_pkg::*;
#(
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] waddr_i,
    input  cache_line             wdata_i,
    input  logic [INDEX_BITS-1:0] raddr_i,
    output cache_line             rdata_o
);
    cache_line mem [0:(1<<INDEX_BITS)-1];
    cache_line rdata_q;
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_q <= mem[raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: line-granular main-memory stand-in answering pmem_* requests after LATENCY cycles.
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    pmem_responder_if.slave  pmem
);
    pmem_state_t           state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d, req_idx;
    cache_line             wdata_q, wdata_d, arr_rdata;
    logic                  wr_q, wr_d, err_q, err_d, req, held;
    assign req_idx = pmem.pmem_address[INDEX_BITS+3:4];
    assign req     = pmem.pmem_read | pmem.pmem_write;
    assign held    = wr_q ? pmem.pmem_write : pmem.pmem_read;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = (LATENCY == 1) ? RESP : BUSY;
                cnt_d   = 8'(LATENCY - 1);
                idx_d   = req_idx;
                wdata_d = pmem.pmem_wdata;
                wr_d    = pmem.pmem_write;
                err_d   = err_q | (pmem.pmem_read & pmem.pmem_write);
            end
            BUSY: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = !held ? IDLE : (cnt_q == 8'd1) ? RESP : BUSY;
            end
            default: state_d = IDLE;
        endcase
    end
    // Read address follows the live request in IDLE so a LATENCY==1 read has data on entering RESP.
    pmem_responder_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk     (clk),
        .we_i    (state_q == RESP && wr_q),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (state_q == IDLE ? req_idx : idx_q),
        .rdata_o (arr_rdata)
    );
    assign pmem.pmem_resp  = (state_q == RESP);
    assign pmem.pmem_rdata = (state_q == RESP && !wr_q) ? arr_rdata : '0;
    assign pmem.pmem_error = err_q;
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: directed vectors against a LATENCY=4 and a LATENCY=1 responder.
module tb_pmem_responder;
    import pmem_responder_pkg::*;
    typedef struct {
        logic      rd;
        logic      wr;
        lc3b_word  addr;
        cache_line wdata;
        cache_line exp;
        string     name;
    } vec_t;
    localparam cache_line L1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam cache_line LA = 128'hAAAA_0000_1111_2222_3333_4444_5555_AAAA;
    localparam cache_line LB = 128'hBBBB_9999_8888_7777_6666_5555_4444_BBBB;
    localparam cache_line LC = 128'hC0C0_C0C0_1234_5678_9ABC_DEF0_0F0F_C0C0;
    localparam cache_line LP = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
    localparam cache_line LQ = 128'h5151_5151_5151_5151_5151_5151_5151_5151;
    localparam cache_line LE = 128'hE0E1_E2E3_E4E5_E6E7_E8E9_EAEB_ECED_EEEF;
    localparam cache_line LW = 128'h0404_0404_4040_4040_0440_0440_4004_4004;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl [10];
    pmem_responder_if ia ();
    pmem_responder_if ib ();
    pmem_responder #(.LATENCY(4), .INDEX_BITS(8)) dut_a (.clk(clk), .reset_n(reset_n), .pmem(ia));
    pmem_responder #(.LATENCY(1), .INDEX_BITS(8)) dut_b (.clk(clk), .reset_n(reset_n), .pmem(ib));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input cache_line act, input cache_line exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // One LATENCY=4 transaction; address/data are scrambled mid-flight to prove they are latched.
    task automatic txn4(input vec_t v);
        @(negedge clk);
        ia.pmem_read = v.rd; ia.pmem_write = v.wr; ia.pmem_address = v.addr; ia.pmem_wdata = v.wdata;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk({v.name, " resp"}, 128'(ia.pmem_resp), 128'(k == 4));
            chk({v.name, " rdata"}, ia.pmem_rdata, (k == 4 && v.rd && !v.wr) ? v.exp : '0);
            if (k == 1) begin ia.pmem_address = v.addr ^ 16'h0ff0; ia.pmem_wdata = ~v.wdata; end
            if (k == 4) begin ia.pmem_read = 1'b0; ia.pmem_write = 1'b0; end
        end
    endtask
    initial begin
        tbl[0] = '{0, 1, 16'h1230, L1, '0, "wr1230"};
        tbl[1] = '{1, 0, 16'h123F, '0, L1, "rd123f"};
        tbl[2] = '{0, 1, 16'h0010, LA, '0, "wrA0010"};
        tbl[3] = '{0, 1, 16'h1010, LB, '0, "wrB1010"};
        tbl[4] = '{1, 0, 16'h0010, '0, LB, "alias0010"};
        tbl[5] = '{0, 1, 16'h0200, LC, '0, "wr0200_post_abort"};
        tbl[6] = '{1, 0, 16'h0200, '0, LC, "rd0200"};
        tbl[7] = '{0, 1, 16'h0300, LP, '0, "wr0300"};
        tbl[8] = '{1, 1, 16'h0500, LE, '0, "rw_conflict"};
        tbl[9] = '{1, 0, 16'h0500, '0, LE, "rd0500_conflict_was_wr"};
        ia.pmem_read = 0; ia.pmem_write = 0; ia.pmem_address = '0; ia.pmem_wdata = '0;
        ib.pmem_read = 0; ib.pmem_write = 0; ib.pmem_address = '0; ib.pmem_wdata = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst a resp", 128'(ia.pmem_resp), '0);
        chk("rst a rdata", ia.pmem_rdata, '0);
        chk("rst a error", 128'(ia.pmem_error), '0);
        chk("rst b resp", 128'(ib.pmem_resp), '0);
        chk("rst b rdata", ib.pmem_rdata, '0);
        chk("rst b error", 128'(ib.pmem_error), '0);
        // Abort: read held two cycles then dropped must never respond.
        @(negedge clk);
        ia.pmem_read = 1'b1; ia.pmem_address = 16'h0200;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("abort resp", 128'(ia.pmem_resp), '0);
            chk("abort rdata", ia.pmem_rdata, '0);
            if (k == 2) ia.pmem_read = 1'b0;
        end
        for (int i = 0; i < 10; i++) txn4(tbl[i]);
        chk("error sticky", 128'(ia.pmem_error), 128'(1));
        // LATENCY=1: write then read in the IDLE cycle after the write's resp.
        @(negedge clk);
        ib.pmem_write = 1'b1; ib.pmem_address = 16'h0040; ib.pmem_wdata = LW;
        @(negedge clk);
        chk("l1 wr resp", 128'(ib.pmem_resp), 128'(1));
        chk("l1 wr rdata", ib.pmem_rdata, '0);
        ib.pmem_write = 1'b0;
        @(negedge clk);
        chk("l1 idle resp", 128'(ib.pmem_resp), '0);
        ib.pmem_read = 1'b1;
        @(negedge clk);
        chk("l1 rd resp", 128'(ib.pmem_resp), 128'(1));
        chk("l1 rd rdata", ib.pmem_rdata, LW);
        ib.pmem_read = 1'b0;
        @(negedge clk);
        chk("l1 after resp", 128'(ib.pmem_resp), '0);
        chk("l1 after rdata", ib.pmem_rdata, '0);
        chk("l1 error clear", 128'(ib.pmem_error), '0);
        // Reset during BUSY of a write: no commit, no resp, error cleared.
        @(negedge clk);
        ia.pmem_write = 1'b1; ia.pmem_address = 16'h0300; ia.pmem_wdata = LQ;
        repeat (2) @(negedge clk);
        chk("busy resp", 128'(ia.pmem_resp), '0);
        chk("busy error", 128'(ia.pmem_error), 128'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("midrst resp", 128'(ia.pmem_resp), '0);
        chk("midrst error", 128'(ia.pmem_error), '0);
        ia.pmem_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        txn4('{1, 0, 16'h0300, '0, LP, "rd0300_after_rst"});
        chk("error after rst", 128'(ia.pmem_error), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
